// File: rtl/eq_cmp_pkg.sv
// Shared types and helpers for the equality-comparator sweep driver.
package eq_cmp_pkg;

  // Sweep controller states
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Counter width able to hold 0..2^(2*width) inclusive
  function automatic int cnt_width(input int width);
    return 2 * width + 1;
  endfunction

endpackage

// File: rtl/eq_cmp_scoreboard.sv
// Pass/fail accumulator for the comparator sweep: counts matches and
// mismatches and remembers the first failing operand pair.
module eq_cmp_scoreboard
  import eq_cmp_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int CNTW  = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             sample,
  input  logic             exp,
  input  logic             aeqb,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [CNTW-1:0]  pass_cnt,
  output logic [CNTW-1:0]  fail_cnt,
  output logic             err,
  output logic [WIDTH-1:0] ff_x,
  output logic [WIDTH-1:0] ff_y
);

  // Accumulate results; an unknown aeqb falls into the mismatch branch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      err      <= 1'b0;
      ff_x     <= '0;
      ff_y     <= '0;
    end else if (clear) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      err      <= 1'b0;
      ff_x     <= '0;
      ff_y     <= '0;
    end else if (sample) begin
      if (aeqb == exp) begin
        pass_cnt <= pass_cnt + CNTW'(1);
      end else begin
        fail_cnt <= fail_cnt + CNTW'(1);
        if (!err) begin
          ff_x <= x;
          ff_y <= y;
          err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/eq_cmp_driver.sv
// Exhaustive stimulus driver for a combinational equality comparator.
// Walks every (x, y) pair, waits SETTLE extra cycles, samples aeqb and
// scores it against x == y.
//
// Handshake: start is a single-cycle request honoured only in IDLE; busy
// stays high from the cycle after acceptance through the DONE cycle, and
// done pulses for exactly that DONE cycle. Results hold until next start.
module eq_cmp_driver
  import eq_cmp_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1,
  parameter int CNTW   = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             aeqb,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [CNTW-1:0]  pass_cnt,
  output logic [CNTW-1:0]  fail_cnt,
  output logic             err,
  output logic [WIDTH-1:0] ff_x,
  output logic [WIDTH-1:0] ff_y
);

  localparam int IW  = 2 * WIDTH;
  // Wait counter must be at least one bit even when SETTLE is 0
  localparam int WCW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

  state_t          state;
  state_t          state_n;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   idx_nxt;
  logic [WCW-1:0]  wc;
  logic            start_ok;
  logic            last_pair;
  logic            sample;
  logic            exp;

  assign start_ok  = (state == S_IDLE) && start;
  assign last_pair = (idx == {IW{1'b1}});
  assign idx_nxt   = idx + IW'(1);
  assign sample    = (state == S_CHECK);
  assign exp       = (x == y);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (start)      state_n = S_SETTLE;
      S_SETTLE: if (wc == '0)   state_n = S_CHECK;
      S_CHECK:  state_n = last_pair ? S_DONE : S_SETTLE;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_IDLE:   busy = 1'b0;
      S_SETTLE: busy = 1'b1;
      S_CHECK:  busy = 1'b1;
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default:  busy = 1'b0;
    endcase
  end

  // Pair index, operand registers and settle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      x   <= '0;
      y   <= '0;
      wc  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            idx <= '0;
            x   <= '0;
            y   <= '0;
            wc  <= WCW'(SETTLE);
          end
        end
        S_SETTLE: begin
          if (wc != '0) wc <= wc - WCW'(1);
        end
        S_CHECK: begin
          if (!last_pair) begin
            idx <= idx_nxt;
            x   <= idx_nxt[IW-1:WIDTH];
            y   <= idx_nxt[WIDTH-1:0];
            wc  <= WCW'(SETTLE);
          end
        end
        default: ;
      endcase
    end
  end

  eq_cmp_scoreboard #(
    .WIDTH (WIDTH),
    .CNTW  (CNTW)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (start_ok),
    .sample   (sample),
    .exp      (exp),
    .aeqb     (aeqb),
    .x        (x),
    .y        (y),
    .pass_cnt (pass_cnt),
    .fail_cnt (fail_cnt),
    .err      (err),
    .ff_x     (ff_x),
    .ff_y     (ff_y)
  );

endmodule

// File: tb/tb_eq_cmp_driver.sv
// Directed bench for eq_cmp_driver: three instances with SETTLE = 1, 0, 3,
// each paired with a behavioural comparator that can be correct or stuck.
module tb_eq_cmp_driver;

  logic clk;
  logic rst_n;

  logic       start_s [3];
  logic       aeqb_w  [3];
  logic [1:0] x_w     [3];
  logic [1:0] y_w     [3];
  logic       busy_w  [3];
  logic       done_w  [3];
  logic [4:0] pass_w  [3];
  logic [4:0] fail_w  [3];
  logic       err_w   [3];
  logic [1:0] ffx_w   [3];
  logic [1:0] ffy_w   [3];

  // comparator model per unit: 0 correct, 1 stuck at 0, 2 stuck at 1
  int mode [3];

  int checks;
  int errors;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_cmp
    assign aeqb_w[g] = (mode[g] == 0) ? (x_w[g] == y_w[g]) : (mode[g] == 2);
  end

  eq_cmp_driver #(.WIDTH(2), .SETTLE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .aeqb(aeqb_w[0]),
    .x(x_w[0]), .y(y_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .pass_cnt(pass_w[0]), .fail_cnt(fail_w[0]), .err(err_w[0]),
    .ff_x(ffx_w[0]), .ff_y(ffy_w[0])
  );

  eq_cmp_driver #(.WIDTH(2), .SETTLE(0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .aeqb(aeqb_w[1]),
    .x(x_w[1]), .y(y_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .pass_cnt(pass_w[1]), .fail_cnt(fail_w[1]), .err(err_w[1]),
    .ff_x(ffx_w[1]), .ff_y(ffy_w[1])
  );

  eq_cmp_driver #(.WIDTH(2), .SETTLE(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .aeqb(aeqb_w[2]),
    .x(x_w[2]), .y(y_w[2]), .busy(busy_w[2]), .done(done_w[2]),
    .pass_cnt(pass_w[2]), .fail_cnt(fail_w[2]), .err(err_w[2]),
    .ff_x(ffx_w[2]), .ff_y(ffy_w[2])
  );

  function automatic int settle_of(input int u);
    if (u == 0) return 1;
    if (u == 1) return 0;
    return 3;
  endfunction

  // all outputs of every unit must read zero
  task automatic test_reset(input string tag);
    for (int u = 0; u < 3; u++) begin
      checks++;
      if (x_w[u] !== 2'd0 || y_w[u] !== 2'd0 || busy_w[u] !== 1'b0 ||
          done_w[u] !== 1'b0 || pass_w[u] !== 5'd0 || fail_w[u] !== 5'd0 ||
          err_w[u] !== 1'b0 || ffx_w[u] !== 2'd0 || ffy_w[u] !== 2'd0) begin
        errors++;
        $display("FAIL %s unit%0d: got x=%0d y=%0d busy=%b done=%b pass=%0d fail=%0d err=%b ff=%0d/%0d, want all 0",
                 tag, u, x_w[u], y_w[u], busy_w[u], done_w[u], pass_w[u],
                 fail_w[u], err_w[u], ffx_w[u], ffy_w[u]);
      end
    end
  endtask

  // Full sweep on unit u with expected end results; extra=1 adds ignored
  // start pulses at edges 5, 20 and in the DONE cycle.
  task automatic test_sweep(input string tag, input int u, input int m,
                            input bit extra, input int ep, input int ef,
                            input bit eerr, input int efx, input int efy);
    int s;
    int last;
    int k;
    s    = settle_of(u);
    last = 16 * (s + 2);
    mode[u] = m;
    @(posedge clk); #1 start_s[u] = 1'b1;
    @(posedge clk); #1 start_s[u] = 1'b0;
    for (int n = 1; n <= last; n++) begin
      @(posedge clk); #1;
      start_s[u] = extra && (n == 4 || n == 19 || n == last);
      @(negedge clk);
      k = n / (s + 2);
      if (k > 15) k = 15;
      checks++;
      if (x_w[u] !== 2'(k >> 2) || y_w[u] !== 2'(k & 3)) begin
        errors++;
        $display("FAIL %s xy n=%0d: got %0d/%0d want %0d/%0d",
                 tag, n, x_w[u], y_w[u], k >> 2, k & 3);
      end
      checks++;
      if (busy_w[u] !== 1'b1 || done_w[u] !== (n == last)) begin
        errors++;
        $display("FAIL %s busy_done n=%0d: got busy=%b done=%b want busy=1 done=%b",
                 tag, n, busy_w[u], done_w[u], n == last);
      end
    end
    @(posedge clk); #1 start_s[u] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (busy_w[u] !== 1'b0 || done_w[u] !== 1'b0 ||
          x_w[u] !== 2'd3 || y_w[u] !== 2'd3) begin
        errors++;
        $display("FAIL %s idle c=%0d: got busy=%b done=%b x=%0d y=%0d want 0 0 3 3",
                 tag, c, busy_w[u], done_w[u], x_w[u], y_w[u]);
      end
      checks++;
      if (pass_w[u] !== 5'(ep) || fail_w[u] !== 5'(ef) || err_w[u] !== eerr ||
          ffx_w[u] !== 2'(efx) || ffy_w[u] !== 2'(efy)) begin
        errors++;
        $display("FAIL %s results c=%0d: got pass=%0d fail=%0d err=%b ff=%0d/%0d want %0d %0d %b %0d/%0d",
                 tag, c, pass_w[u], fail_w[u], err_w[u], ffx_w[u], ffy_w[u],
                 ep, ef, eerr, efx, efy);
      end
    end
    mode[u] = 0;
  endtask

  task automatic test_correct();
    test_sweep("correct_s1", 0, 0, 1'b0, 16, 0, 1'b0, 0, 0);
  endtask

  task automatic test_stuck();
    test_sweep("stuck0", 0, 1, 1'b0, 12, 4, 1'b1, 0, 0);
    test_sweep("stuck1", 0, 2, 1'b0, 4, 12, 1'b1, 0, 1);
    // a clean sweep after failures must clear err and first-fail pair
    test_sweep("clear_after_fail", 0, 0, 1'b0, 16, 0, 1'b0, 0, 0);
  endtask

  task automatic test_extra_start();
    test_sweep("extra_start", 0, 0, 1'b1, 16, 0, 1'b0, 0, 0);
  endtask

  task automatic test_mid_reset();
    mode[0] = 1;
    @(posedge clk); #1 start_s[0] = 1'b1;
    @(posedge clk); #1 start_s[0] = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 test_reset("mid_reset_async");
    @(negedge clk) rst_n = 1'b1;
    mode[0] = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (busy_w[0] !== 1'b0 || done_w[0] !== 1'b0 || x_w[0] !== 2'd0 ||
          pass_w[0] !== 5'd0 || fail_w[0] !== 5'd0) begin
        errors++;
        $display("FAIL post_reset_idle c=%0d: got busy=%b done=%b x=%0d pass=%0d fail=%0d want all 0",
                 c, busy_w[0], done_w[0], x_w[0], pass_w[0], fail_w[0]);
      end
    end
    test_sweep("after_reset", 0, 0, 1'b0, 16, 0, 1'b0, 0, 0);
  endtask

  task automatic test_settle_variants();
    test_sweep("settle0", 1, 0, 1'b0, 16, 0, 1'b0, 0, 0);
    test_sweep("settle3", 2, 0, 1'b0, 16, 0, 1'b0, 0, 0);
    test_sweep("settle3_stuck1", 2, 2, 1'b0, 4, 12, 1'b1, 0, 1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    for (int u = 0; u < 3; u++) begin
      start_s[u] = 1'b0;
      mode[u]    = 0;
    end
    #2 test_reset("reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_reset("idle_after_release");
    test_correct();
    test_stuck();
    test_extra_start();
    test_mid_reset();
    test_settle_variants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
